// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one shared memory port.
// One outstanding transaction, round-robin on contention, sticky wait-timeout flag.
//
// state | meaning
// IDLE  | no transaction outstanding; grant any valid requester this cycle
// BUSY  | latched request driven downstream; waiting for mresp_data_ok
module mem_bus_arbiter #(
  parameter int INIT_PRIO = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_data_ok,
  input  logic [63:0] mresp_data,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  localparam logic       INIT_OWNER  = (INIT_PRIO != 0);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        grant, grant_instr;
  logic        last_grant;
  logic [7:0]  wait_cnt, wait_inc;
  logic [63:0] lat_addr, lat_data;
  logic [2:0]  lat_size;
  logic [7:0]  lat_strobe;
  logic        resp_fire;

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_instr = 1'b0;
    case (state)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          grant       = 1'b1;
          state_nxt   = BUSY;
          // owner encoding: 1 = instruction, so contention favours ~last_grant
          grant_instr = (ireq_valid && dreq_valid) ? ~last_grant : ireq_valid;
        end
      end
      BUSY: begin
        if (mresp_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= INIT_OWNER;
      last_grant <= ~INIT_OWNER;
      wait_cnt   <= 8'd0;
      err        <= 1'b0;
      lat_addr   <= 64'd0;
      lat_size   <= 3'd0;
      lat_strobe <= 8'd0;
      lat_data   <= 64'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_instr;
        last_grant <= grant_instr;
        wait_cnt   <= 8'd0;
        if (grant_instr) begin
          lat_addr   <= ireq_addr;
          lat_size   <= 3'b010;
          lat_strobe <= 8'd0;
          lat_data   <= 64'd0;
        end else begin
          lat_addr   <= dreq_addr;
          lat_size   <= dreq_size;
          lat_strobe <= dreq_strobe;
          lat_data   <= dreq_data;
        end
      end else if (state == BUSY && !mresp_data_ok) begin
        wait_cnt <= wait_inc;
        if (wait_inc >= TIMEOUT_CNT) err <= 1'b1;
      end
    end
  end

  assign busy        = (state == BUSY);
  assign mreq_valid  = busy;
  assign mreq_addr   = lat_addr;
  assign mreq_size   = lat_size;
  assign mreq_strobe = lat_strobe;
  assign mreq_data   = lat_data;

  // reset cycle suppresses any response even though state is still BUSY
  assign resp_fire     = busy && mresp_data_ok && !rst;
  assign iresp_data_ok = resp_fire && owner;
  assign dresp_data_ok = resp_fire && !owner;
  assign iresp_data    = lat_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
  assign dresp_data    = mresp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = 64'd0;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = 64'd0;
  logic [2:0]  dreq_size = 3'd0;
  logic [7:0]  dreq_strobe = 8'd0;
  logic [63:0] dreq_data = 64'd0;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_data_ok = 1'b0;
  logic [63:0] mresp_data = 64'd0;
  logic        busy, owner, err;

  mem_bus_arbiter #(.INIT_PRIO(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: the one outstanding transaction and arbitration history
  logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_err = 1'b0;
  int          m_wait = 0;
  logic [63:0] m_addr = 64'd0, m_data = 64'd0;
  logic [2:0]  m_size = 3'd0;
  logic [7:0]  m_strobe = 8'd0;
  logic        e_iok, e_dok, last_iok = 1'b0, last_dok = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    e_iok = m_busy && mresp_data_ok && !rst && m_owner;
    e_dok = m_busy && mresp_data_ok && !rst && !m_owner;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("mreq_valid", 64'(mreq_valid), 64'(m_busy));
    chk("owner", 64'(owner), 64'(m_owner));
    chk("err", 64'(err), 64'(m_err));
    chk("iresp_data_ok", 64'(iresp_data_ok), 64'(e_iok));
    chk("dresp_data_ok", 64'(dresp_data_ok), 64'(e_dok));
    if (m_busy) begin
      chk("mreq_addr", mreq_addr, m_addr);
      chk("mreq_size", 64'(mreq_size), 64'(m_size));
      chk("mreq_strobe", 64'(mreq_strobe), 64'(m_strobe));
      chk("mreq_data", mreq_data, m_data);
    end
    if (e_iok) chk("iresp_data", 64'(iresp_data), m_addr[2] ? 64'(mresp_data[63:32]) : 64'(mresp_data[31:0]));
    if (e_dok) chk("dresp_data", dresp_data, mresp_data);
  endtask

  task automatic model_clock();
    logic pick;
    if (rst) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_wait = 0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (ireq_valid || dreq_valid) begin
        pick = (ireq_valid && dreq_valid) ? !m_last : ireq_valid;
        m_owner = pick; m_last = pick; m_wait = 0; m_busy = 1'b1;
        if (pick) begin
          m_addr = ireq_addr; m_size = 3'd2; m_strobe = 8'd0; m_data = 64'd0;
        end else begin
          m_addr = dreq_addr; m_size = dreq_size; m_strobe = dreq_strobe; m_data = dreq_data;
        end
      end
    end else if (mresp_data_ok) begin
      m_busy = 1'b0;
    end else begin
      m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
      if (m_wait >= TMO) m_err = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_compare();
    last_iok = e_iok;
    last_dok = e_dok;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ireq_valid = 1'b0; dreq_valid = 1'b0; mresp_data_ok = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [0:3] exp_seq = 4'b0101;
  int bcyc = 0, target = 1;

  initial begin
    // reset state
    step();
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst owner", 64'(owner), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst mreq_valid", 64'(mreq_valid), 64'd0);
    rst = 1'b0;
    step();

    // single fetch, response on 3rd BUSY cycle
    ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_8000_0004;
    step();
    #1;
    chk("fetch busy", 64'(busy), 64'd1);
    chk("fetch owner", 64'(owner), 64'd1);
    chk("fetch mreq_addr", mreq_addr, 64'h0000_0000_8000_0004);
    chk("fetch mreq_size", 64'(mreq_size), 64'd2);
    chk("fetch mreq_strobe", 64'(mreq_strobe), 64'd0);
    step();
    step();
    mresp_data_ok = 1'b1; mresp_data = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("fetch iresp_data_ok", 64'(iresp_data_ok), 64'd1);
    chk("fetch iresp_data", 64'(iresp_data), 64'h1234_5678);
    chk("fetch dresp_data_ok", 64'(dresp_data_ok), 64'd0);
    step();
    ireq_valid = 1'b0; mresp_data_ok = 1'b0;
    #1;
    chk("fetch done ok", 64'(iresp_data_ok), 64'd0);
    chk("fetch done busy", 64'(busy), 64'd0);

    // contention after reset alternates D,I,D,I with one-cycle bubbles
    do_reset();
    ireq_valid = 1'b1; dreq_valid = 1'b1; mresp_data_ok = 1'b1;
    ireq_addr = 64'h100; dreq_addr = 64'h200; dreq_size = 3'd3; dreq_strobe = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("rr busy", 64'(busy), 64'd1);
      chk("rr owner", 64'(owner), 64'(exp_seq[k]));
      step();
      #1;
      chk("rr bubble", 64'(busy), 64'd0);
      chk("rr idle ok", 64'(iresp_data_ok | dresp_data_ok), 64'd0);
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0; mresp_data_ok = 1'b0;
    step();

    // store passthrough, fields latched at grant
    do_reset();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_0010; dreq_size = 3'd3;
    dreq_strobe = 8'hFF; dreq_data = 64'hDEAD_BEEF;
    step();
    dreq_data = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("st mreq_addr", mreq_addr, 64'h8000_0010);
    chk("st mreq_size", 64'(mreq_size), 64'd3);
    chk("st mreq_strobe", 64'(mreq_strobe), 64'hFF);
    chk("st mreq_data", mreq_data, 64'hDEAD_BEEF);
    step();
    mresp_data_ok = 1'b1;
    #1;
    chk("st mreq_data held", mreq_data, 64'hDEAD_BEEF);
    chk("st dresp_data_ok", 64'(dresp_data_ok), 64'd1);
    step();
    dreq_valid = 1'b0; mresp_data_ok = 1'b0;
    step();

    // timeout: err after the 4th BUSY cycle, transaction continues
    do_reset();
    ireq_valid = 1'b1; ireq_addr = 64'h40;
    step();
    step(); step(); step();
    #1;
    chk("tmo err early", 64'(err), 64'd0);
    step();
    #1;
    chk("tmo err", 64'(err), 64'd1);
    chk("tmo busy", 64'(busy), 64'd1);
    step();
    mresp_data_ok = 1'b1;
    #1;
    chk("tmo iresp_data_ok", 64'(iresp_data_ok), 64'd1);
    step();
    ireq_valid = 1'b0; mresp_data_ok = 1'b0;
    #1;
    chk("tmo err sticky", 64'(err), 64'd1);
    chk("tmo idle", 64'(busy), 64'd0);

    // reset mid-transaction
    dreq_valid = 1'b1;
    step();
    step();
    rst = 1'b1; dreq_valid = 1'b0; mresp_data_ok = 1'b1;
    #1;
    chk("rstmid ok in rst", 64'(dresp_data_ok), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rstmid dresp_ok", 64'(dresp_data_ok), 64'd0);
    chk("rstmid iresp_ok", 64'(iresp_data_ok), 64'd0);
    chk("rstmid err", 64'(err), 64'd0);
    chk("rstmid owner", 64'(owner), 64'd0);
    step();
    mresp_data_ok = 1'b0;
    step();

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (last_iok) ireq_valid = ($urandom_range(0, 1) == 1);
      else if (!ireq_valid) ireq_valid = ($urandom_range(0, 2) == 0);
      else if (m_busy && m_owner && $urandom_range(0, 29) == 0) ireq_valid = 1'b0;
      if (last_dok) dreq_valid = ($urandom_range(0, 1) == 1);
      else if (!dreq_valid) dreq_valid = ($urandom_range(0, 2) == 0);
      else if (m_busy && !m_owner && $urandom_range(0, 29) == 0) dreq_valid = 1'b0;
      ireq_addr   = {$urandom, $urandom} & ~64'h3;
      dreq_addr   = {$urandom, $urandom};
      dreq_size   = 3'($urandom_range(0, 7));
      dreq_strobe = 8'($urandom);
      dreq_data   = {$urandom, $urandom};
      mresp_data  = {$urandom, $urandom};
      if (m_busy) begin
        bcyc++;
        if (bcyc == 1) target = $urandom_range(1, 5);
        mresp_data_ok = (bcyc >= target);
      end else begin
        bcyc = 0;
        mresp_data_ok = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: INIT_PRIO, default 0, requester favoured on first contention after reset (0 = data, 1 = instruction).
REQ-002 Parameter: TIMEOUT, default 255, cycles in BUSY without mresp_data_ok before err sets (1..255).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ireq_valid  in  1  instruction fetch request, held until iresp_data_ok.
REQ-006 ireq_addr  in  64  fetch address, 4-byte aligned.
REQ-007 iresp_data_ok  out  1  fetch response strobe.
REQ-008 iresp_data  out  32  fetched instruction word.
REQ-009 dreq_valid  in  1  data request, held until dresp_data_ok.
REQ-010 dreq_addr / dreq_size / dreq_strobe / dreq_data  in  64/3/8/64  data request fields; strobe 0 = load.
REQ-011 dresp_data_ok  out  1  data response strobe.
REQ-012 dresp_data  out  64  raw 64-bit load data.
REQ-013 mreq_valid / mreq_addr / mreq_size / mreq_strobe / mreq_data  out  1/64/3/8/64  shared downstream memory request.
REQ-014 mresp_data_ok / mresp_data  in  1/64  downstream response.
REQ-015 busy  out  1  transaction outstanding; owner  out  1  current/last grantee (0 = data, 1 = instruction); err  out  1  sticky timeout flag.

Function
REQ-016 States: IDLE, BUSY; the block SHALL hold at most one downstream transaction at a time.
REQ-017 IDLE, no valid request: stay IDLE; mreq_valid = 0.
REQ-018 IDLE, exactly one valid: grant it; next cycle BUSY, owner = grantee.
REQ-019 IDLE, both valid: grant the requester not granted last (round-robin via last-grant register); after reset first contention goes to INIT_PRIO.
REQ-020 On grant, the request fields SHALL be latched; in BUSY, mreq_* SHALL be driven from the latched copy, mreq_valid = 1, independent of requester inputs.
REQ-021 Instruction grant: mreq_addr = ireq_addr, mreq_size = 3'b010, mreq_strobe = 0, mreq_data = 0.
REQ-022 Data grant: mreq_* = dreq_* unchanged.
REQ-023 BUSY and mresp_data_ok: combinationally, same cycle, assert owner's *_data_ok; next cycle IDLE.
REQ-024 iresp_data = mresp_data[63:32] if latched addr[2] = 1, else mresp_data[31:0]; dresp_data = mresp_data.
REQ-025 Non-owner *_data_ok SHALL be 0 at all times; both *_data_ok 0 in IDLE; mresp_data_ok in IDLE ignored.
REQ-026 IDLE after completion SHALL last exactly one cycle before the next grant (one-cycle bubble); a requester still valid then counts as a new request.
REQ-027 busy = 1 exactly in BUSY.
REQ-028 Wait counter, 8 bits: cleared on grant; increments each BUSY cycle without mresp_data_ok; saturates at 255.
REQ-029 Counter reaching TIMEOUT SHALL set err; err remains set until rst; the transaction is not aborted and stays BUSY.
REQ-030 Requester dropping valid while owning: ignored; transaction completes from latched fields; response still pulsed.

Reset
REQ-031 rst SHALL force IDLE, mreq_valid = 0, busy = 0, owner = INIT_PRIO, last-grant = INIT_PRIO complement, counter = 0, err = 0, all *_data_ok = 0.
REQ-032 rst during BUSY SHALL abandon the transaction; a later mresp_data_ok is ignored; no response is pulsed.
REQ-033 rst has priority over all simultaneous events.

Verification
REQ-034 Single fetch: ireq_valid = 1, addr 0x8000_0004; mresp_data_ok on 3rd BUSY cycle with data 0x1234_5678_9ABC_DEF0 -> mreq_size = 2, strobe = 0, iresp_data_ok one cycle, iresp_data = 0x1234_5678, dresp_data_ok = 0.
REQ-035 Contention after reset (INIT_PRIO = 0): both valid at once -> data granted first, instruction granted after one IDLE bubble; repeated contention alternates grants D,I,D,I.
REQ-036 Store passthrough: dreq addr 0x8000_0010, size 3, strobe 0xFF, data 0xDEAD_BEEF -> mreq_* equal the inputs; requester changes dreq_data mid-BUSY -> mreq_data stays 0xDEAD_BEEF.
REQ-037 Timeout: TIMEOUT = 4, no mresp_data_ok -> err rises after the 4th BUSY cycle, busy stays 1; a later data_ok completes normally; err stays 1.
REQ-038 Reset mid-transaction: rst during BUSY, then mresp_data_ok -> mreq_valid = 0 the cycle after rst, no *_data_ok pulse, err = 0, owner = INIT_PRIO.
